// File: rtl/atomic_alu_if.sv
// atomic_alu_if: command/load/display bundle between the board controls and the ALU core
interface atomic_alu_if #(
  parameter int DATA_W = 8,
  parameter int NREGS = 8,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int CMD_W = 3 + 3 * ADDR_W
);
  logic run;
  logic [CMD_W-1:0] command;
  logic load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic busy;
  logic done;
  logic [DATA_W-1:0] result;
  logic carry;
  logic zero;
  logic cas_ok;
  modport master (
    output run, command, load_en, load_addr, load_data, rd_addr,
    input rd_data, busy, done, result, carry, zero, cas_ok
  );
  modport slave (
    input run, command, load_en, load_addr, load_data, rd_addr,
    output rd_data, busy, done, result, carry, zero, cas_ok
  );
endinterface

// File: rtl/atomic_alu_core.sv
// atomic_alu_core: register-file ALU with atomic SWAP/CAS, run-edge triggered 4-phase FSM
module atomic_alu_core #(
  parameter int DATA_W = 8,
  parameter int NREGS = 8,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int CMD_W = 3 + 3 * ADDR_W
) (
  input logic clk,
  input logic rst,
  atomic_alu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_MOV, OP_SWAP, OP_CAS} op_t;
  state_t state;
  op_t op;
  logic run_q;
  logic [ADDR_W-1:0] a1, a2, a3;
  logic [DATA_W-1:0] v1, v2, v3;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W:0] sum, diff;
  logic [DATA_W-1:0] res_c;
  logic carry_c;
  assign sum = {1'b0, v1} + {1'b0, v2};
  assign diff = {1'b0, v1} - {1'b0, v2};
  // MOV/SWAP/CAS all report the old R[a1] and leave carry alone
  assign res_c = op == OP_ADD ? sum[DATA_W-1:0] :
                 op == OP_SUB ? diff[DATA_W-1:0] :
                 op == OP_OR  ? v1 | v2 :
                 op == OP_AND ? v1 & v2 :
                 op == OP_XOR ? v1 ^ v2 : v1;
  assign carry_c = op == OP_ADD ? sum[DATA_W] :
                   op == OP_SUB ? diff[DATA_W] :
                   op <= OP_XOR ? 1'b0 : bus.carry;
  assign bus.rd_data = regs[bus.rd_addr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= DATA_W'(i);
      state <= IDLE;
      op <= OP_ADD;
      run_q <= 1'b0;
      {a1, a2, a3} <= '0;
      {v1, v2, v3} <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.result <= '0;
      bus.carry <= 1'b0;
      bus.zero <= 1'b0;
      bus.cas_ok <= 1'b0;
    end else begin
      run_q <= bus.run;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_en) regs[bus.load_addr] <= bus.load_data;
          if (bus.run && !run_q) begin
            state <= READ;
            bus.busy <= 1'b1;
          end
        end
        READ: begin
          // a load committed on the trigger edge is already visible here
          op <= op_t'(bus.command[CMD_W-1 -: 3]);
          a1 <= bus.command[3*ADDR_W-1 -: ADDR_W];
          a2 <= bus.command[2*ADDR_W-1 -: ADDR_W];
          a3 <= bus.command[ADDR_W-1:0];
          v1 <= regs[bus.command[3*ADDR_W-1 -: ADDR_W]];
          v2 <= regs[bus.command[2*ADDR_W-1 -: ADDR_W]];
          v3 <= regs[bus.command[ADDR_W-1:0]];
          state <= EXEC;
        end
        EXEC: begin
          bus.result <= res_c;
          bus.carry <= carry_c;
          bus.zero <= res_c == '0;
          bus.cas_ok <= op == OP_CAS && v1 == v2;
          state <= WRITE;
        end
        WRITE: begin
          if (op <= OP_XOR) regs[NREGS-1] <= bus.result;
          if (op == OP_MOV) regs[a3] <= v1;
          if (op == OP_SWAP) begin
            regs[a1] <= v2;
            regs[a2] <= v1;
          end
          if (op == OP_CAS && bus.cas_ok) regs[a1] <= v3;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_atomic_alu_core.sv
// tb_atomic_alu_core: directed + random ops against an arithmetic reference model
module tb_atomic_alu_core;
  logic clk = 0;
  logic rst = 1;
  int errors = 0;
  int checks = 0;
  int m [8];
  int e_res = 0, e_carry = 0, e_zero = 0, e_ok = 0;
  always #5 clk = ~clk;
  atomic_alu_if #(.DATA_W(8), .NREGS(8)) bus ();
  atomic_alu_core #(.DATA_W(8), .NREGS(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr = 3'(i);
      #1;
      chk($sformatf("%s R%0d", tag, i), {24'd0, bus.rd_data}, 32'(m[i]));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m[i] = i;
    {e_res, e_carry, e_zero, e_ok} = '0;
  endtask

  task automatic load(input int la, input int ld);
    @(negedge clk);
    bus.load_en = 1; bus.load_addr = 3'(la); bus.load_data = 8'(ld);
    @(negedge clk);
    bus.load_en = 0;
    m[la] = ld;
  endtask

  // mode 0: plain, 1: load in the trigger cycle, 2: load attempted while busy
  task automatic do_op(input int op, input int a1, input int a2, input int a3,
                       input int hold, input int mode, input int la, input int ld);
    int v1, v2, v3, s, dk, extra;
    if (mode == 1) m[la] = ld;
    v1 = m[a1]; v2 = m[a2]; v3 = m[a3];
    e_ok = 0;
    case (op)
      0: begin s = v1 + v2; e_res = s % 256; e_carry = int'(s > 255); end
      1: begin e_res = (v1 - v2 + 256) % 256; e_carry = int'(v1 < v2); end
      2: begin e_res = v1 | v2; e_carry = 0; end
      3: begin e_res = v1 & v2; e_carry = 0; end
      4: begin e_res = v1 ^ v2; e_carry = 0; end
      5: begin e_res = v1; m[a3] = v1; end
      6: begin e_res = v1; m[a1] = v2; m[a2] = v1; end
      default: begin e_res = v1; if (v1 == v2) begin m[a1] = v3; e_ok = 1; end end
    endcase
    if (op <= 4) m[7] = e_res;
    e_zero = int'(e_res == 0);
    @(negedge clk);
    bus.command = {3'(op), 3'(a1), 3'(a2), 3'(a3)};
    bus.run = 1;
    bus.load_en = (mode == 1);
    bus.load_addr = 3'(la);
    bus.load_data = 8'(ld);
    dk = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) bus.load_en = (mode == 2);
      if (k == 3) bus.load_en = 0;
      if (bus.done) begin dk = k; break; end
      if (k < 4) chk("busy_during_op", {31'd0, bus.busy}, 1);
    end
    chk("done_latency", dk, 4);
    chk("busy_at_done", {31'd0, bus.busy}, 0);
    extra = 0;
    for (int j = 0; j < hold; j++) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    bus.run = 0;
    @(negedge clk);
    if (bus.done) extra++;
    chk("single_done", extra, 0);
    chk("result", {24'd0, bus.result}, 32'(e_res));
    chk("carry", {31'd0, bus.carry}, 32'(e_carry));
    chk("zero", {31'd0, bus.zero}, 32'(e_zero));
    chk("cas_ok", {31'd0, bus.cas_ok}, 32'(e_ok));
    chk_regs($sformatf("op%0d", op));
  endtask

  initial begin
    int seen;
    bus.run = 0; bus.command = '0; bus.load_en = 0; bus.load_addr = '0;
    bus.load_data = '0; bus.rd_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_result", {24'd0, bus.result}, 0);
    chk("rst_flags", {29'd0, bus.carry, bus.zero, bus.cas_ok}, 0);
    chk_regs("reset");
    rst = 0;
    do_op(0, 1, 2, 0, 100, 0, 0, 0);
    do_op(1, 1, 2, 0, 1, 0, 0, 0);
    do_op(4, 3, 3, 0, 1, 0, 0, 0);
    load(2, 1);
    do_op(7, 1, 2, 3, 1, 0, 0, 0);
    do_op(7, 1, 2, 3, 1, 0, 0, 0);
    do_op(6, 4, 5, 0, 1, 0, 0, 0);
    do_op(6, 6, 6, 0, 1, 0, 0, 0);
    do_op(5, 4, 0, 2, 2, 0, 0, 0);
    do_op(0, 0, 0, 0, 1, 2, 0, 8'hAA);
    do_op(0, 0, 1, 0, 1, 1, 0, 8'hAA);
    // reset in the middle of EXEC: nothing commits, no done pulse
    @(negedge clk);
    bus.command = {3'd0, 3'd1, 3'd2, 3'd0};
    bus.run = 1;
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    chk("midrst_busy", {31'd0, bus.busy}, 0);
    bus.run = 0;
    @(negedge clk);
    rst = 0;
    model_reset();
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("midrst_no_done", seen, 0);
    chk("midrst_result", {24'd0, bus.result}, 0);
    chk_regs("midrst");
    do_op(0, 1, 2, 0, 1, 0, 0, 0);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) load($urandom_range(0, 7), $urandom_range(0, 255));
      do_op($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 2),
            $urandom_range(0, 7), $urandom_range(0, 255));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
